// File: rtl/karatsuba_pkg.sv
// Shared constants for the sequential Karatsuba multiplier and its benches.
package karatsuba_pkg;

  // Controller state encoding.
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StMul     = 3'd2;
  localparam logic [2:0] StMul0    = 3'd3;
  localparam logic [2:0] StMul1    = 3'd4;
  localparam logic [2:0] StMul2    = 3'd5;
  localparam logic [2:0] StCombine = 3'd6;
  localparam logic [2:0] StHold    = 3'd7;

  // Half operand width H.
  function automatic int unsigned half_w(input int unsigned w);
    return w / 2;
  endfunction

  // Sub-multiplier operand width M = H+1 (room for the carry of hi+lo).
  function automatic int unsigned sub_w(input int unsigned w);
    return w / 2 + 1;
  endfunction

  // Accept edge to the edge after which valid_out is high, three parallel units.
  function automatic int unsigned lat_par(input int unsigned w);
    return w / 2 + 5;
  endfunction

  // Same, with one time-shared unit.
  function automatic int unsigned lat_seq(input int unsigned w);
    return 3 * (w / 2) + 11;
  endfunction

endpackage

// File: rtl/mult_seq.sv
// Radix-2 shift-add unsigned multiplier. A start pulse loads the operands; M cycles
// later done pulses for one cycle with the 2M-bit product on p.
module mult_seq #(
  parameter int unsigned M = 33
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M-1:0]   a,
  input  logic [M-1:0]   b,
  output logic           done,
  output logic [2*M-1:0] p
);

  localparam int unsigned CW = $clog2(M + 1);

  logic [2*M-1:0] acc_q, acc_d;
  logic [2*M-1:0] mcand_q, mcand_d;
  logic [M-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_q, done_d;

  // One multiplier bit per cycle; done fires on the step that consumes the last bit.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{M{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CW'(M);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      done_d   = (cnt_q == CW'(1));
    end
  end

  // Datapath and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
  assign p    = acc_q;

endmodule

// File: rtl/karatsuba_mul_seq.sv
// Sequential one-level Karatsuba multiplier with signed/unsigned mode and a
// valid/ready result hold. z0 = lo*lo, z1 = hi*hi, z2 = (hi+lo)*(hi+lo).
module karatsuba_mul_seq
  import karatsuba_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned PARALLEL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic [2*WIDTH-1:0] P,
  output logic               valid_out,
  input  logic               ready_in
);

  localparam int unsigned H  = half_w(WIDTH);
  localparam int unsigned M  = sub_w(WIDTH);
  localparam int unsigned ZW = 2 * M;
  localparam int unsigned PW = 2 * WIDTH;

  logic [2:0]       state_q, state_d;
  logic             mstart_q, mstart_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic             neg_q;
  logic [H-1:0]     a_lo_q, a_hi_q, b_lo_q, b_hi_q;
  logic [H:0]       sa_q, sb_q;
  logic [ZW-1:0]    z0_q, z1_q, z2_q;
  logic [ZW-1:0]    z0_in, z1_in, z2_in;
  logic             mul_done;
  logic [PW-1:0]    p_q;
  logic             valid_q;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [ZW-1:0]    mid;
  logic [PW-1:0]    mag, result;

  // Next state and the one-cycle start pulse towards the sub-multipliers.
  always_comb begin
    state_d  = state_q;
    mstart_d = 1'b0;
    case (state_q)
      StIdle: if (start) state_d = StLoad;
      StLoad: begin
        mstart_d = 1'b1;
        state_d  = (PARALLEL != 0) ? StMul : StMul0;
      end
      StMul:  if (mul_done) state_d = StCombine;
      StMul0: if (mul_done) begin
        state_d  = StMul1;
        mstart_d = 1'b1;
      end
      StMul1: if (mul_done) begin
        state_d  = StMul2;
        mstart_d = 1'b1;
      end
      StMul2:    if (mul_done) state_d = StCombine;
      StCombine: state_d = StHold;
      StHold:    if (ready_in) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Controller state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mstart_q <= mstart_d;
    end
  end

  // Magnitudes; the most-negative value maps to 2^(WIDTH-1) without overflow.
  always_comb begin
    mag_a = (signed_q && a_q[WIDTH-1]) ? (~a_q + WIDTH'(1)) : a_q;
    mag_b = (signed_q && b_q[WIDTH-1]) ? (~b_q + WIDTH'(1)) : b_q;
  end

  // Operand capture at accept, then halves and H+1-bit sums in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      neg_q    <= 1'b0;
      a_lo_q   <= '0;
      a_hi_q   <= '0;
      b_lo_q   <= '0;
      b_hi_q   <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
    end else if (state_q == StIdle && start) begin
      a_q      <= A;
      b_q      <= B;
      signed_q <= signed_mode;
    end else if (state_q == StLoad) begin
      neg_q  <= signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
      a_lo_q <= mag_a[H-1:0];
      a_hi_q <= mag_a[WIDTH-1:H];
      b_lo_q <= mag_b[H-1:0];
      b_hi_q <= mag_b[WIDTH-1:H];
      sa_q   <= {1'b0, mag_a[WIDTH-1:H]} + {1'b0, mag_a[H-1:0]};
      sb_q   <= {1'b0, mag_b[WIDTH-1:H]} + {1'b0, mag_b[H-1:0]};
    end
  end

  if (PARALLEL != 0) begin : g_par
    logic [2:0] done_v;

    mult_seq #(.M(M)) u_z0 (
      .clk  (clk),
      .rst  (rst),
      .start(mstart_q),
      .a    ({1'b0, a_lo_q}),
      .b    ({1'b0, b_lo_q}),
      .done (done_v[0]),
      .p    (z0_in)
    );

    mult_seq #(.M(M)) u_z1 (
      .clk  (clk),
      .rst  (rst),
      .start(mstart_q),
      .a    ({1'b0, a_hi_q}),
      .b    ({1'b0, b_hi_q}),
      .done (done_v[1]),
      .p    (z1_in)
    );

    mult_seq #(.M(M)) u_z2 (
      .clk  (clk),
      .rst  (rst),
      .start(mstart_q),
      .a    (sa_q),
      .b    (sb_q),
      .done (done_v[2]),
      .p    (z2_in)
    );

    assign mul_done = &done_v;
  end else begin : g_seq
    logic [M-1:0]  op_a, op_b;
    logic [ZW-1:0] prod;

    // Operand mux; the unit samples it on the edge after each start pulse is raised.
    always_comb begin
      op_a = {1'b0, a_lo_q};
      op_b = {1'b0, b_lo_q};
      if (state_q == StMul1) begin
        op_a = {1'b0, a_hi_q};
        op_b = {1'b0, b_hi_q};
      end else if (state_q == StMul2) begin
        op_a = sa_q;
        op_b = sb_q;
      end
    end

    mult_seq #(.M(M)) u_z (
      .clk  (clk),
      .rst  (rst),
      .start(mstart_q),
      .a    (op_a),
      .b    (op_b),
      .done (mul_done),
      .p    (prod)
    );

    assign z0_in = prod;
    assign z1_in = prod;
    assign z2_in = prod;
  end

  // Partial products are captured while the matching done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z0_q <= '0;
      z1_q <= '0;
      z2_q <= '0;
    end else if (mul_done) begin
      case (state_q)
        StMul: begin
          z0_q <= z0_in;
          z1_q <= z1_in;
          z2_q <= z2_in;
        end
        StMul0:  z0_q <= z0_in;
        StMul1:  z1_q <= z1_in;
        StMul2:  z2_q <= z2_in;
        default: ;
      endcase
    end
  end

  // Recombination; mid is non-negative and fits in 2H+2 bits.
  always_comb begin
    mid    = z2_q - z1_q - z0_q;
    mag    = (PW'(z1_q) << WIDTH) + (PW'(mid) << H) + PW'(z0_q);
    result = neg_q ? (~mag + PW'(1)) : mag;
  end

  // Result register and valid; P keeps its value after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q     <= '0;
      valid_q <= 1'b0;
    end else if (state_q == StCombine) begin
      p_q     <= result;
      valid_q <= 1'b1;
    end else if (state_q == StHold && ready_in) begin
      valid_q <= 1'b0;
    end
  end

  assign busy      = (state_q != StIdle);
  assign P         = p_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_karatsuba_mul_seq.sv
// Bench for karatsuba_mul_seq: four configurations (8/64 bits, parallel/shared)
// share stimulus; one at a time is exercised and compared with a plain product model.
module tb_karatsuba_mul_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   st;
  logic         sm_in;
  logic [63:0]  a_in, b_in;
  logic         ready_in;
  logic [3:0]   busy_v, valid_v;
  logic [15:0]  p_w8p, p_w8s;
  logic [127:0] p_w64p, p_w64s;

  logic [1:0]   cur;
  logic         obs_valid, obs_busy;
  logic [127:0] obs_p;
  logic [127:0] exp_p;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  karatsuba_mul_seq #(.WIDTH(8), .PARALLEL(1)) u_w8p (
    .clk(clk), .rst(rst), .start(st[0]), .signed_mode(sm_in), .A(a_in[7:0]), .B(b_in[7:0]),
    .busy(busy_v[0]), .P(p_w8p), .valid_out(valid_v[0]), .ready_in(ready_in)
  );
  karatsuba_mul_seq #(.WIDTH(8), .PARALLEL(0)) u_w8s (
    .clk(clk), .rst(rst), .start(st[1]), .signed_mode(sm_in), .A(a_in[7:0]), .B(b_in[7:0]),
    .busy(busy_v[1]), .P(p_w8s), .valid_out(valid_v[1]), .ready_in(ready_in)
  );
  karatsuba_mul_seq #(.WIDTH(64), .PARALLEL(1)) u_w64p (
    .clk(clk), .rst(rst), .start(st[2]), .signed_mode(sm_in), .A(a_in), .B(b_in),
    .busy(busy_v[2]), .P(p_w64p), .valid_out(valid_v[2]), .ready_in(ready_in)
  );
  karatsuba_mul_seq #(.WIDTH(64), .PARALLEL(0)) u_w64s (
    .clk(clk), .rst(rst), .start(st[3]), .signed_mode(sm_in), .A(a_in), .B(b_in),
    .busy(busy_v[3]), .P(p_w64s), .valid_out(valid_v[3]), .ready_in(ready_in)
  );

  always_comb begin
    obs_valid = valid_v[cur];
    obs_busy  = busy_v[cur];
    case (cur)
      2'd0:    obs_p = {112'b0, p_w8p};
      2'd1:    obs_p = {112'b0, p_w8s};
      2'd2:    obs_p = p_w64p;
      default: obs_p = p_w64s;
    endcase
  end

  // Reference: exact integer product reduced to 2w bits.
  function automatic logic [127:0] model(input logic smv, input logic [63:0] a,
                                         input logic [63:0] b, input int w);
    logic [127:0] ea, eb, pr;
    if (w == 8) begin
      ea = smv ? {{120{a[7]}}, a[7:0]} : {120'b0, a[7:0]};
      eb = smv ? {{120{b[7]}}, b[7:0]} : {120'b0, b[7:0]};
      pr = ea * eb;
      return {112'b0, pr[15:0]};
    end
    ea = smv ? {{64{a[63]}}, a} : {64'b0, a};
    eb = smv ? {{64{b[63]}}, b} : {64'b0, b};
    pr = ea * eb;
    return pr;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Issue one operation on DUT sel and wait (bounded) for valid_out; on return the
  // time is just after the edge where valid rose. poke_at>0 re-pulses start with
  // other operands that many cycles after the accept edge.
  task automatic launch(input logic [1:0] sel, input logic smv, input logic [63:0] a,
                        input logic [63:0] b, input int poke_at);
    int w, lat, cyc;
    w   = (sel < 2'd2) ? 8 : 64;
    lat = (sel == 2'd0 || sel == 2'd2) ? (w / 2 + 5) : (3 * (w / 2) + 11);
    cur = sel;
    @(negedge clk);
    st = '0;
    st[sel] = 1'b1;
    a_in  = a;
    b_in  = b;
    sm_in = smv;
    exp_p = model(smv, a, b, w);
    @(posedge clk);
    #1;
    st = '0;
    check("busy_after_accept", {127'b0, obs_busy}, 128'd1);
    cyc = 0;
    while (!obs_valid && cyc < lat + 8) begin
      @(posedge clk);
      #1;
      cyc++;
      st = '0;
      if (cyc == poke_at) begin
        st[sel] = 1'b1;
        a_in    = ~a;
        b_in    = b ^ 64'h5;
        sm_in   = ~smv;
      end
    end
    st = '0;
    check("latency", 128'(cyc), 128'(lat));
    check("product", obs_p, exp_p);
  endtask

  // Full operation with ready_in high: valid must be a single-cycle pulse.
  task automatic run_op(input logic [1:0] sel, input logic smv, input logic [63:0] a,
                        input logic [63:0] b, input int poke_at);
    launch(sel, smv, a, b, poke_at);
    @(posedge clk);
    #1;
    check("valid_pulse_end", {127'b0, obs_valid}, 128'd0);
    check("idle_after_ack", {127'b0, obs_busy}, 128'd0);
    check("p_kept", obs_p, exp_p);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        smr;
    int          seen;

    rst      = 1'b1;
    st       = '0;
    sm_in    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    ready_in = 1'b1;
    cur      = 2'd0;
    exp_p    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state of every configuration.
    for (int s = 0; s < 4; s++) begin
      cur = 2'(s);
      #1;
      check("reset_valid", {127'b0, obs_valid}, 128'd0);
      check("reset_busy", {127'b0, obs_busy}, 128'd0);
      check("reset_p", obs_p, 128'd0);
    end

    // Directed 8-bit cases.
    run_op(2'd0, 1'b0, 64'hFF, 64'hFF, 0);
    check("ff_x_ff", obs_p, 128'hFE01);
    run_op(2'd1, 1'b1, 64'h80, 64'h80, 0);
    check("neg_sq_8", obs_p, 128'h4000);
    run_op(2'd1, 1'b1, 64'h80, 64'h01, 0);
    check("neg_x_one_8", obs_p, 128'hFF80);
    run_op(2'd0, 1'b1, 64'h7F, 64'h81, 0);
    run_op(2'd1, 1'b0, 64'h00, 64'hA5, 0);

    // 64-bit boundaries on both schedules: carries, most-negative, zero.
    for (int s = 2; s < 4; s++) begin
      run_op(2'(s), 1'b0, '1, '1, 0);
      run_op(2'(s), 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0);
      check("neg_sq_64", obs_p, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
      run_op(2'(s), 1'b1, '1, 64'h8000_0000_0000_0000, 0);
      run_op(2'(s), 1'b0, 64'h0, 64'hDEAD_BEEF_0123_4567, 0);
      check("zero_64", obs_p, 128'd0);
    end

    // Start while busy is ignored; result reflects the first operands.
    run_op(2'd2, 1'b1, 64'hFEDC_BA98_7654_3210, 64'h0F0F_F0F0_1234_5678, 5);
    run_op(2'd3, 1'b0, 64'h1357_9BDF_2468_ACE0, 64'hFFFF_0000_FFFF_0001, 40);
    run_op(2'd1, 1'b0, 64'h0C, 64'h0D, 3);

    // Backpressure: valid, P and busy hold; a start during HOLD is dropped.
    ready_in = 1'b0;
    launch(2'd0, 1'b0, 64'h5A, 64'hC3, 0);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", {127'b0, obs_valid}, 128'd1);
      check("hold_p", obs_p, exp_p);
      check("hold_busy", {127'b0, obs_busy}, 128'd1);
      st = '0;
      if (i == 3) begin
        st[0] = 1'b1;
        a_in  = 64'h11;
        b_in  = 64'h22;
      end
      @(posedge clk);
      #1;
    end
    st = '0;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    check("ack_valid_drop", {127'b0, obs_valid}, 128'd0);
    check("ack_busy_drop", {127'b0, obs_busy}, 128'd0);
    check("ack_p_kept", obs_p, 128'h5A * 128'hC3);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (obs_busy || obs_valid) seen++;
    end
    check("no_queued_op", 128'(seen), 128'd0);

    // Reset in the middle of MUL1 on the shared-unit 8-bit configuration.
    cur = 2'd1;
    @(negedge clk);
    st[1] = 1'b1;
    a_in  = 64'h77;
    b_in  = 64'h99;
    sm_in = 1'b0;
    @(posedge clk);
    #1;
    st = '0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", {127'b0, obs_busy}, 128'd0);
    check("rst_valid", {127'b0, obs_valid}, 128'd0);
    check("rst_p", obs_p, 128'd0);
    @(posedge clk);
    #1;
    check("rst_p_next", obs_p, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (obs_valid || obs_p != '0) seen++;
    end
    check("no_partial_after_rst", 128'(seen), 128'd0);
    run_op(2'd1, 1'b0, 64'd3, 64'd5, 0);
    check("three_x_five", obs_p, 128'd15);

    // Randomized operands on both 64-bit schedules.
    for (int s = 2; s < 4; s++) begin
      for (int i = 0; i < 500; i++) begin
        ra  = {$urandom(), $urandom()};
        rb  = {$urandom(), $urandom()};
        smr = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          0: ra = '1;
          1: rb = 64'h8000_0000_0000_0000;
          2: begin ra = 64'hFFFF_FFFF_8000_0001; rb = 64'h8000_0001_FFFF_FFFF; end
          3: ra = {32'h0, ra[31:0]};
          default: ;
        endcase
        run_op(2'(s), smr, ra, rb, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
